hp_controller: RTL and testbench



---
 rtl/hp_controller.sv | 140 ++++++++++++++
 tb/tb_hp_controller.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hp_controller.sv
// Player hit-point owner: arbitrates damage/heal requests, saturates HP to 0..HP_MAX,
// and sequences the ALIVE / COOL (post-hit invulnerability) / DEAD life cycle.
module hp_controller #(
  parameter int HP_MAX   = 10,
  parameter int HP_INIT  = 10,
  parameter int COOL_CYC = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       DMG_REQ,
  input  logic [3:0] DMG_AMT,
  input  logic       HEAL_REQ,
  input  logic [3:0] HEAL_AMT,
  input  logic       REVIVE,
  output logic       DMG_ACK,
  output logic       HEAL_ACK,
  output logic [3:0] HP,
  output logic       DEAD,
  output logic       INVULN
);

  localparam logic [3:0] HP_RST    = 4'((HP_INIT > HP_MAX) ? HP_MAX : HP_INIT);
  localparam logic [3:0] HP_TOP    = 4'(HP_MAX);
  localparam logic [4:0] HP_CAP    = 5'(HP_MAX);
  localparam logic [7:0] COOL_LOAD = 8'(COOL_CYC - 1);

  // One-hot so DEAD and INVULN come straight off state flops.
  typedef enum logic [2:0] {
    ST_ALIVE = 3'b001,
    ST_COOL  = 3'b010,
    ST_DEAD  = 3'b100
  } state_e;

  // Handshake: a requester raises *_REQ with a stable *_AMT and holds both until the
  // matching *_ACK pulse; dropping REQ before ACK withdraws the request. No grant is
  // made while any ACK is high, so a still-held request is never counted twice.

  state_e     state_q, state_d;
  logic [3:0] hp_q, hp_d;
  logic [7:0] cnt_q, cnt_d;
  logic       rr_q, rr_d;          // 0: damage wins a tie, 1: heal wins a tie
  logic       dmg_ack_q, dmg_ack_d;
  logic       heal_ack_q, heal_ack_d;

  logic       gap, dmg_elig, heal_elig, both_elig;
  logic       dmg_gnt, heal_gnt, dmg_hit, dmg_kill;
  logic [4:0] dmg_diff, heal_sum;
  logic [3:0] dmg_res, heal_res;

  always_comb begin
    gap       = dmg_ack_q | heal_ack_q;
    dmg_elig  = DMG_REQ & (state_q == ST_ALIVE) & ~gap;
    heal_elig = HEAL_REQ & (state_q != ST_DEAD) & ~gap;
    both_elig = dmg_elig & heal_elig;
    dmg_gnt   = dmg_elig & (~heal_elig | ~rr_q);
    heal_gnt  = heal_elig & ~dmg_gnt;

    // Borrow out of the 5-bit difference means the hit exceeds the remaining HP.
    dmg_diff  = {1'b0, hp_q} - {1'b0, DMG_AMT};
    dmg_res   = dmg_diff[4] ? 4'd0 : dmg_diff[3:0];
    heal_sum  = {1'b0, hp_q} + {1'b0, HEAL_AMT};
    heal_res  = (heal_sum > HP_CAP) ? HP_TOP : heal_sum[3:0];

    dmg_hit   = dmg_gnt & (DMG_AMT != 4'd0) & (dmg_res != 4'd0);
    dmg_kill  = dmg_gnt & (DMG_AMT != 4'd0) & (dmg_res == 4'd0);
  end

  // State register plus the datapath registers that move with it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_ALIVE;
      hp_q       <= HP_RST;
      cnt_q      <= 8'd0;
      rr_q       <= 1'b0;
      dmg_ack_q  <= 1'b0;
      heal_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hp_q       <= hp_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      dmg_ack_q  <= dmg_ack_d;
      heal_ack_q <= heal_ack_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ALIVE: begin
        if (dmg_kill)     state_d = ST_DEAD;
        else if (dmg_hit) state_d = ST_COOL;
      end
      ST_COOL: begin
        if (dmg_kill)                          state_d = ST_DEAD;
        else if (cnt_q == 8'd0 && !heal_gnt)   state_d = ST_ALIVE;
      end
      ST_DEAD: begin
        if (REVIVE) state_d = ST_ALIVE;
      end
      default: state_d = ST_ALIVE;
    endcase
  end

  // Datapath next values: HP, cooldown counter, tie pointer, acknowledges.
  always_comb begin
    hp_d       = hp_q;
    cnt_d      = cnt_q;
    rr_d       = both_elig ? ~rr_q : rr_q;
    dmg_ack_d  = dmg_gnt;
    heal_ack_d = heal_gnt;

    if (state_q == ST_DEAD) begin
      if (REVIVE) hp_d = HP_RST;
    end else if (dmg_gnt) begin
      hp_d = dmg_res;
    end else if (heal_gnt) begin
      hp_d = heal_res;
    end

    if (dmg_hit) begin
      cnt_d = COOL_LOAD;
    end else if (dmg_kill) begin
      cnt_d = 8'd0;
    end else if (state_q == ST_COOL && !heal_gnt && cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // Output logic.
  always_comb begin
    HP       = hp_q;
    DMG_ACK  = dmg_ack_q;
    HEAL_ACK = heal_ack_q;
    DEAD     = state_q[2];
    INVULN   = state_q[1];
  end

endmodule

// File: tb/tb_hp_controller.sv
// Bench for hp_controller: directed scenarios on two parameterisations plus a
// randomized run compared against a cycle-level behavioural model of the HP rules.
module tb_hp_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance a: defaults (HP_MAX=10, HP_INIT=10, COOL_CYC=4)
  logic       a_dreq = 1'b0, a_hreq = 1'b0, a_rev = 1'b0;
  logic [3:0] a_damt = 4'd0, a_hamt = 4'd0;
  logic       a_dack, a_hack, a_dead, a_inv;
  logic [3:0] a_hp;

  // Instance b: HP_INIT above HP_MAX, one-cycle cooldown
  logic       b_dreq = 1'b0, b_hreq = 1'b0, b_rev = 1'b0;
  logic [3:0] b_damt = 4'd0, b_hamt = 4'd0;
  logic       b_dack, b_hack, b_dead, b_inv;
  logic [3:0] b_hp;

  hp_controller u_dut_a (
    .CLK(clk), .RST(rst_n),
    .DMG_REQ(a_dreq), .DMG_AMT(a_damt), .HEAL_REQ(a_hreq), .HEAL_AMT(a_hamt),
    .REVIVE(a_rev), .DMG_ACK(a_dack), .HEAL_ACK(a_hack), .HP(a_hp),
    .DEAD(a_dead), .INVULN(a_inv)
  );

  hp_controller #(.HP_MAX(10), .HP_INIT(15), .COOL_CYC(1)) u_dut_b (
    .CLK(clk), .RST(rst_n),
    .DMG_REQ(b_dreq), .DMG_AMT(b_damt), .HEAL_REQ(b_hreq), .HEAL_AMT(b_hamt),
    .REVIVE(b_rev), .DMG_ACK(b_dack), .HEAL_ACK(b_hack), .HP(b_hp),
    .DEAD(b_dead), .INVULN(b_inv)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- reference model for instance a ----------------
  int m_hp, m_inv_left;
  bit m_dead, m_dack, m_hack, m_dmg_first;

  task automatic model_init();
    m_hp = 10; m_inv_left = 0; m_dead = 0; m_dack = 0; m_hack = 0; m_dmg_first = 1;
  endtask

  // Advances the model across one rising edge using the inputs that were stable at it.
  task automatic model_step();
    bit blocked, d_ok, h_ok, take_d, take_h;
    blocked = m_dack || m_hack;
    m_dack = 0;
    m_hack = 0;
    if (m_dead) begin
      if (a_rev) begin m_dead = 0; m_hp = 10; end
    end else begin
      d_ok   = a_dreq && (m_inv_left == 0) && !blocked;
      h_ok   = a_hreq && !blocked;
      take_d = d_ok && (!h_ok || m_dmg_first);
      take_h = h_ok && !take_d;
      if (d_ok && h_ok) m_dmg_first = !m_dmg_first;
      if (take_d) begin
        m_dack = 1;
        if (a_damt != 0) begin
          if (int'(a_damt) >= m_hp) begin m_hp = 0; m_dead = 1; m_inv_left = 0; end
          else begin m_hp = m_hp - int'(a_damt); m_inv_left = 4; end
        end
      end else if (take_h) begin
        m_hack = 1;
        m_hp = (m_hp + int'(a_hamt) > 10) ? 10 : m_hp + int'(a_hamt);
      end else if (m_inv_left > 0) begin
        m_inv_left = m_inv_left - 1;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    a_dreq = 1; a_damt = 4'd3;
    tick();
    a_dreq = 0;
    tick();
    checks++; if (a_inv !== 1'b1) begin errors++; $display("FAIL rst_pre_cool inv got %b want 1", a_inv); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (a_hp !== 4'd10) begin errors++; $display("FAIL rst_hp got %0d want 10", a_hp); end
    checks++; if (a_dead !== 1'b0) begin errors++; $display("FAIL rst_dead got %b want 0", a_dead); end
    checks++; if (a_inv !== 1'b0) begin errors++; $display("FAIL rst_inv got %b want 0", a_inv); end
    checks++; if (a_dack !== 1'b0 || a_hack !== 1'b0) begin errors++; $display("FAIL rst_acks got %b%b want 00", a_dack, a_hack); end
    checks++; if (b_hp !== 4'd10) begin errors++; $display("FAIL rst_init_clamp got %0d want 10", b_hp); end
    @(negedge clk) rst_n = 1'b1;
    #1;
    checks++; if (a_hp !== 4'd10 || a_inv !== 1'b0) begin errors++; $display("FAIL rst_release hp %0d inv %b want 10 0", a_hp, a_inv); end
  endtask

  task automatic test_damage_cool();
    int inv_cycles;
    bit got;
    a_dreq = 1; a_damt = 4'd3;
    tick();
    checks++; if (a_dack !== 1'b1) begin errors++; $display("FAIL dmg1_ack got %b want 1", a_dack); end
    checks++; if (a_hp !== 4'd7) begin errors++; $display("FAIL dmg1_hp got %0d want 7", a_hp); end
    checks++; if (a_inv !== 1'b1) begin errors++; $display("FAIL dmg1_inv got %b want 1", a_inv); end
    a_damt = 4'd2;
    inv_cycles = 1;
    got = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (a_dack === 1'b1) begin got = 1; break; end
      if (a_inv === 1'b1) inv_cycles++;
    end
    checks++; if (!got) begin errors++; $display("FAIL dmg2_ack_timeout got none want ack within 12 cycles"); end
    checks++; if (inv_cycles != 4) begin errors++; $display("FAIL cool_len got %0d want 4", inv_cycles); end
    checks++; if (a_hp !== 4'd5) begin errors++; $display("FAIL dmg2_hp got %0d want 5", a_hp); end
    a_dreq = 0;
    repeat (6) tick();
    checks++; if (a_inv !== 1'b0) begin errors++; $display("FAIL dmg2_cool_end inv got %b want 0", a_inv); end
  endtask

  task automatic test_death_revive();
    int acks;
    a_dreq = 1; a_damt = 4'd1;
    tick();
    checks++; if (a_hp !== 4'd4) begin errors++; $display("FAIL pre_death_hp got %0d want 4", a_hp); end
    a_dreq = 0;
    repeat (6) tick();
    a_dreq = 1; a_damt = 4'd12;
    tick();
    checks++; if (a_hp !== 4'd0 || a_dead !== 1'b1) begin errors++; $display("FAIL death_edge hp %0d dead %b want 0 1", a_hp, a_dead); end
    checks++; if (a_inv !== 1'b0 || a_dack !== 1'b1) begin errors++; $display("FAIL death_inv_ack inv %b ack %b want 0 1", a_inv, a_dack); end
    a_dreq = 0;
    tick();
    a_dreq = 1; a_damt = 4'd2; a_hreq = 1; a_hamt = 4'd1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (a_dack === 1'b1 || a_hack === 1'b1) acks++;
      if (a_hp !== 4'd0 || a_dead !== 1'b1) acks++;
    end
    checks++; if (acks != 0) begin errors++; $display("FAIL dead_no_grant got %0d events want 0", acks); end
    a_rev = 1;
    tick();
    a_rev = 0;
    checks++; if (a_hp !== 4'd10 || a_dead !== 1'b0) begin errors++; $display("FAIL revive hp %0d dead %b want 10 0", a_hp, a_dead); end
    checks++; if (a_dack !== 1'b0 || a_hack !== 1'b0) begin errors++; $display("FAIL revive_acks got %b%b want 00", a_dack, a_hack); end
    tick();
    checks++; if (a_dack !== 1'b1 || a_hack !== 1'b0 || a_hp !== 4'd8) begin errors++; $display("FAIL post_revive dack %b hack %b hp %0d want 1 0 8", a_dack, a_hack, a_hp); end
    a_dreq = 0;
    tick();
    checks++; if (a_hack !== 1'b0) begin errors++; $display("FAIL gap_after_ack hack got %b want 0", a_hack); end
    tick();
    checks++; if (a_hack !== 1'b1 || a_hp !== 4'd9 || a_inv !== 1'b1) begin errors++; $display("FAIL heal_in_cool hack %b hp %0d inv %b want 1 9 1", a_hack, a_hp, a_inv); end
    a_hreq = 0;
    repeat (6) tick();
    checks++; if (a_inv !== 1'b0 || a_hp !== 4'd9) begin errors++; $display("FAIL cool_after_heal inv %b hp %0d want 0 9", a_inv, a_hp); end
  endtask

  task automatic test_zero_amount();
    a_dreq = 1; a_damt = 4'd0;
    tick();
    checks++; if (a_dack !== 1'b1 || a_hp !== 4'd9 || a_inv !== 1'b0) begin errors++; $display("FAIL zero_dmg ack %b hp %0d inv %b want 1 9 0", a_dack, a_hp, a_inv); end
    a_dreq = 0;
    tick();
    a_hreq = 1; a_hamt = 4'd0;
    tick();
    checks++; if (a_hack !== 1'b1 || a_hp !== 4'd9) begin errors++; $display("FAIL zero_heal ack %b hp %0d want 1 9", a_hack, a_hp); end
    a_hreq = 0;
    tick();
  endtask

  task automatic test_alternate();
    logic exp_d, exp_h, prev_any;
    logic [3:0] exp_hp;
    b_dreq = 1; b_damt = 4'd5;
    tick();
    checks++; if (b_hp !== 4'd5) begin errors++; $display("FAIL alt_setup_hp got %0d want 5", b_hp); end
    b_dreq = 0;
    tick();
    tick();
    b_dreq = 1; b_damt = 4'd1; b_hreq = 1; b_hamt = 4'd1;
    prev_any = 1'b0;
    for (int t = 0; t < 12; t++) begin
      tick();
      exp_d  = (t % 4 == 0);
      exp_h  = (t % 4 == 2);
      exp_hp = (t % 4 < 2) ? 4'd4 : 4'd5;
      checks++; if (b_dack !== exp_d || b_hack !== exp_h) begin errors++; $display("FAIL alt_acks t=%0d got %b%b want %b%b", t, b_dack, b_hack, exp_d, exp_h); end
      checks++; if (b_hp !== exp_hp) begin errors++; $display("FAIL alt_hp t=%0d got %0d want %0d", t, b_hp, exp_hp); end
      checks++; if (prev_any && (b_dack || b_hack)) begin errors++; $display("FAIL alt_adjacent t=%0d got ack after ack want gap", t); end
      prev_any = b_dack | b_hack;
    end
    b_dreq = 0; b_hreq = 0;
    tick();
    b_hreq = 1; b_hamt = 4'd4;
    tick();
    checks++; if (b_hack !== 1'b1 || b_hp !== 4'd9) begin errors++; $display("FAIL heal4 ack %b hp %0d want 1 9", b_hack, b_hp); end
    b_hreq = 0;
    tick();
    b_hreq = 1; b_hamt = 4'd15;
    tick();
    checks++; if (b_hack !== 1'b1 || b_hp !== 4'd10) begin errors++; $display("FAIL heal_sat ack %b hp %0d want 1 10", b_hack, b_hp); end
    b_hreq = 0;
    tick();
    b_hreq = 1; b_hamt = 4'd3;
    tick();
    checks++; if (b_hack !== 1'b1 || b_hp !== 4'd10) begin errors++; $display("FAIL heal_at_max ack %b hp %0d want 1 10", b_hack, b_hp); end
    b_hreq = 0;
    tick();
  endtask

  task automatic test_random();
    apply_reset();
    a_dreq = 0; a_hreq = 0; a_rev = 0;
    model_init();
    for (int c = 0; c < 400; c++) begin
      tick();
      model_step();
      checks++; if (a_hp !== 4'(m_hp)) begin errors++; $display("FAIL rnd_hp c=%0d got %0d want %0d", c, a_hp, m_hp); end
      checks++; if (a_dead !== m_dead) begin errors++; $display("FAIL rnd_dead c=%0d got %b want %b", c, a_dead, m_dead); end
      checks++; if (a_inv !== (m_inv_left > 0)) begin errors++; $display("FAIL rnd_inv c=%0d got %b want %b", c, a_inv, (m_inv_left > 0)); end
      checks++; if (a_dack !== m_dack) begin errors++; $display("FAIL rnd_dack c=%0d got %b want %b", c, a_dack, m_dack); end
      checks++; if (a_hack !== m_hack) begin errors++; $display("FAIL rnd_hack c=%0d got %b want %b", c, a_hack, m_hack); end
      if (a_dreq) begin
        if (m_dack || $urandom_range(0, 19) == 0) a_dreq = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        a_dreq = 1;
        a_damt = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 4));
      end
      if (a_hreq) begin
        if (m_hack || $urandom_range(0, 19) == 0) a_hreq = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        a_hreq = 1;
        a_hamt = 4'($urandom_range(0, 15));
      end
      a_rev = ($urandom_range(0, 9) == 0);
    end
    a_dreq = 0; a_hreq = 0; a_rev = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_damage_cool();
    test_death_revive();
    test_zero_amount();
    test_alternate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
